// File: rtl/config_chain_loader_pkg.sv
// Shared types for the configuration chain loader: FSM state encoding and a
// parameter sanity check used at elaboration.
package config_chain_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      LOAD,
      SHIFT,
      DONE
   } state_t;

   function automatic bit chain_length_ok(input int chain_length);
      return chain_length >= 1;
   endfunction

endpackage

// File: rtl/config_chain_loader.sv
// Clears a tile configuration shift chain, then streams handshaked bitstream
// words into it MSB-first, one bit per cycle, until CHAIN_LENGTH bits are in.
module config_chain_loader
   import config_chain_loader_pkg::*;
#(
   parameter int WORD_WIDTH   = 32,
   parameter int CHAIN_LENGTH = 36,
   parameter int COUNT_WIDTH  = $clog2(CHAIN_LENGTH + 1)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  word_valid,
   input  logic [WORD_WIDTH-1:0] word_data,
   output logic                  word_ready,
   output logic                  config_nreset,
   output logic                  config_enable,
   output logic                  config_data,
   output logic                  busy,
   output logic                  done
);

   localparam int IDX_WIDTH = $clog2(WORD_WIDTH + 1);
   localparam logic [COUNT_WIDTH-1:0] COUNT_LAST = COUNT_WIDTH'(CHAIN_LENGTH - 1);
   localparam logic [IDX_WIDTH-1:0]   IDX_LAST   = IDX_WIDTH'(WORD_WIDTH - 1);

   if (!chain_length_ok(CHAIN_LENGTH)) begin : g_bad_chain_length
      $error("config_chain_loader: CHAIN_LENGTH must be at least 1");
   end

   state_t                 state_q, state_d;
   logic [WORD_WIDTH-1:0]  buffer_q, buffer_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic [IDX_WIDTH-1:0]   index_q, index_d;
   logic                   word_ready_q, word_ready_d;
   logic                   config_nreset_q, config_nreset_d;
   logic                   config_enable_q, config_enable_d;
   logic                   config_data_q, config_data_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;

   // config_data_q carries the bit being shifted now; buffer_q holds the bits still to come.
   always_comb begin
      state_d       = state_q;
      buffer_d      = buffer_q;
      count_d       = count_q;
      index_d       = index_q;
      config_data_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            count_d = '0;
            index_d = '0;
            if (start) state_d = CLEAR;
         end
         CLEAR: state_d = LOAD;
         LOAD: begin
            if (word_valid && word_ready_q) begin
               config_data_d = word_data[WORD_WIDTH-1];
               buffer_d      = word_data << 1;
               index_d       = '0;
               state_d       = SHIFT;
            end
         end
         SHIFT: begin
            count_d = count_q + COUNT_WIDTH'(1);
            index_d = index_q + IDX_WIDTH'(1);
            if (count_q == COUNT_LAST) begin
               state_d = DONE;
            end else if (index_q == IDX_LAST) begin
               state_d = LOAD;
            end else begin
               config_data_d = buffer_q[WORD_WIDTH-1];
               buffer_d      = buffer_q << 1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      word_ready_d    = (state_d == LOAD);
      config_nreset_d = (state_d != CLEAR);
      config_enable_d = (state_d == SHIFT);
      busy_d          = (state_d != IDLE);
      done_d          = (state_d == DONE);
   end

   // Outputs are registered from the next state so each one lines up with the state it describes.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q         <= IDLE;
         buffer_q        <= '0;
         count_q         <= '0;
         index_q         <= '0;
         word_ready_q    <= 1'b0;
         config_nreset_q <= 1'b0;
         config_enable_q <= 1'b0;
         config_data_q   <= 1'b0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         buffer_q        <= buffer_d;
         count_q         <= count_d;
         index_q         <= index_d;
         word_ready_q    <= word_ready_d;
         config_nreset_q <= config_nreset_d;
         config_enable_q <= config_enable_d;
         config_data_q   <= config_data_d;
         busy_q          <= busy_d;
         done_q          <= done_d;
      end
   end

   assign word_ready    = word_ready_q;
   assign config_nreset = config_nreset_q;
   assign config_enable = config_enable_q;
   assign config_data   = config_data_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule

// File: tb/tb_config_chain_loader.sv
// Self-checking bench for config_chain_loader: three instances (chain lengths
// 36, 64 and 1) driven from a vector table, with a serial-bit scoreboard.
module tb_config_chain_loader;

   logic        clock = 1'b0;
   logic        reset;
   logic        start [3];
   logic        word_valid [3];
   logic [31:0] word_data [3];
   logic        word_ready [3];
   logic        config_nreset [3];
   logic        config_enable [3];
   logic        config_data [3];
   logic        busy [3];
   logic        done [3];

   int checks   = 0;
   int failures = 0;

   bit          exp_q [3][$];
   logic [63:0] chain_m [3];

   typedef struct {
      int          dut;
      logic [31:0] w0;
      logic [31:0] w1;
      int          stall;
      bit          extra_start;
      logic [63:0] exp_chain;
      int          exp_done;
      int          exp_words;
   } vec_t;

   vec_t vecs [9];

   always #5 clock = ~clock;

   config_chain_loader #(.WORD_WIDTH(32), .CHAIN_LENGTH(36)) dut36 (
      .clock(clock), .reset(reset), .start(start[0]), .word_valid(word_valid[0]),
      .word_data(word_data[0]), .word_ready(word_ready[0]), .config_nreset(config_nreset[0]),
      .config_enable(config_enable[0]), .config_data(config_data[0]), .busy(busy[0]), .done(done[0]));

   config_chain_loader #(.WORD_WIDTH(32), .CHAIN_LENGTH(64)) dut64 (
      .clock(clock), .reset(reset), .start(start[1]), .word_valid(word_valid[1]),
      .word_data(word_data[1]), .word_ready(word_ready[1]), .config_nreset(config_nreset[1]),
      .config_enable(config_enable[1]), .config_data(config_data[1]), .busy(busy[1]), .done(done[1]));

   config_chain_loader #(.WORD_WIDTH(32), .CHAIN_LENGTH(1)) dut1 (
      .clock(clock), .reset(reset), .start(start[2]), .word_valid(word_valid[2]),
      .word_data(word_data[2]), .word_ready(word_ready[2]), .config_nreset(config_nreset[2]),
      .config_enable(config_enable[2]), .config_data(config_data[2]), .busy(busy[2]), .done(done[2]));

   function automatic int chainLen(input int d);
      return (d == 0) ? 36 : (d == 1) ? 64 : 1;
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic pushBits(input int d, input logic [31:0] w, input int clen, inout int pushed);
      for (int k = 31; k >= 0; k--) begin
         if (pushed < clen) begin
            exp_q[d].push_back(w[k]);
            pushed++;
         end
      end
   endtask

   // Each shifted bit is checked against the scoreboard and appended to the chain model.
   always @(negedge clock) begin
      for (int d = 0; d < 3; d++) begin
         if (config_enable[d] === 1'b1) begin
            checkOutput("shift_expected", exp_q[d].size() != 0, 1);
            if (exp_q[d].size() != 0)
               checkOutput("serial_bit", config_data[d], exp_q[d].pop_front());
            chain_m[d] = {chain_m[d][62:0], config_data[d]};
         end
      end
   end

   task automatic applyStimulus(input int v);
      vec_t        t;
      int          d, clen, widx, stall_cnt, pushed, done_cyc, done_cnt, busy_after;
      int          cyc, rem, acc, nbits;
      logic [31:0] words [2];
      logic [127:0] rdy_m, en_m, nrst_m, busy_m, er, ee, eb;
      logic [63:0] cmask;
      t = vecs[v];
      d = t.dut;
      clen = chainLen(d);
      words[0] = t.w0;
      words[1] = t.w1;
      widx = 0; stall_cnt = 0; pushed = 0; done_cyc = -1; done_cnt = 0; busy_after = 0;
      rdy_m = '0; en_m = '0; nrst_m = '0; busy_m = '0;
      exp_q[d].delete();
      @(negedge clock);
      for (int c = 0; c < 200; c++) begin
         if (c < 128) begin
            rdy_m[c]  = word_ready[d];
            en_m[c]   = config_enable[d];
            nrst_m[c] = ~config_nreset[d];
            busy_m[c] = busy[d];
         end
         if (done[d] === 1'b1) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (done_cyc >= 0 && c > done_cyc && busy[d] !== 1'b0) busy_after++;
         if (done_cyc >= 0 && c >= done_cyc + 4) break;
         start[d] = (c == 0) || (t.extra_start && (c == 5 || c == 20));
         if (word_ready[d] === 1'b1) begin
            word_data[d]  = words[(widx > 1) ? 1 : widx];
            word_valid[d] = (stall_cnt >= t.stall);
            if (word_valid[d]) begin
               pushBits(d, word_data[d], clen, pushed);
               widx++;
               stall_cnt = 0;
            end else begin
               stall_cnt++;
            end
         end else begin
            word_valid[d] = (t.stall == 0);
            word_data[d]  = $urandom;
         end
         @(negedge clock);
      end
      start[d] = 1'b0;
      word_valid[d] = 1'b0;

      // Timing model: ready through each stall, one accept, then up to 32 shift cycles.
      er = '0; ee = '0; eb = '0;
      cyc = 2; rem = clen;
      while (rem > 0) begin
         for (int k = 0; k <= t.stall; k++) er[cyc + k] = 1'b1;
         acc = cyc + t.stall;
         nbits = (rem < 32) ? rem : 32;
         for (int k = 1; k <= nbits; k++) ee[acc + k] = 1'b1;
         rem -= nbits;
         cyc = acc + nbits + 1;
      end
      for (int k = 1; k <= cyc; k++) eb[k] = 1'b1;
      cmask = (clen >= 64) ? '1 : ((64'd1 << clen) - 64'd1);

      checkOutput($sformatf("v%0d_done_cycle", v), done_cyc, t.exp_done);
      checkOutput($sformatf("v%0d_done_count", v), done_cnt, 1);
      checkOutput($sformatf("v%0d_busy_after_done", v), busy_after, 0);
      checkOutput($sformatf("v%0d_words", v), widx, t.exp_words);
      checkOutput($sformatf("v%0d_chain", v), chain_m[d] & cmask, t.exp_chain);
      checkOutput($sformatf("v%0d_ready_cycles", v), rdy_m, er);
      checkOutput($sformatf("v%0d_enable_cycles", v), en_m, ee);
      checkOutput($sformatf("v%0d_nreset_low_cycles", v), nrst_m, 128'h2);
      checkOutput($sformatf("v%0d_busy_cycles", v), busy_m, eb);
      checkOutput($sformatf("v%0d_bits_left", v), exp_q[d].size(), 0);
   endtask

   initial begin
      vecs[0] = '{0, 32'hA5A5A5A5, 32'hF0000000, 0, 1'b0, 64'hA5A5A5A5F, 40, 2};
      vecs[1] = '{0, 32'hA5A5A5A5, 32'hF0000000, 5, 1'b0, 64'hA5A5A5A5F, 50, 2};
      vecs[2] = '{0, 32'h12345678, 32'h9FFFFFFF, 0, 1'b0, 64'h123456789, 40, 2};
      vecs[3] = '{0, 32'hFFFFFFFF, 32'h0000000F, 2, 1'b0, 64'hFFFFFFFF0, 44, 2};
      vecs[4] = '{0, 32'hA5A5A5A5, 32'hF0000000, 0, 1'b1, 64'hA5A5A5A5F, 40, 2};
      vecs[5] = '{1, 32'hDEADBEEF, 32'h01234567, 0, 1'b0, 64'hDEADBEEF01234567, 68, 2};
      vecs[6] = '{1, 32'hDEADBEEF, 32'h01234567, 3, 1'b0, 64'hDEADBEEF01234567, 74, 2};
      vecs[7] = '{2, 32'h80000000, 32'h00000000, 0, 1'b0, 64'h1, 4, 1};
      vecs[8] = '{2, 32'h7FFFFFFF, 32'hFFFFFFFF, 2, 1'b0, 64'h0, 6, 1};

      for (int d = 0; d < 3; d++) begin
         start[d] = 1'b0;
         word_valid[d] = 1'b0;
         word_data[d] = '0;
         chain_m[d] = '0;
      end
      reset = 1'b1;
      repeat (2) @(negedge clock);
      for (int d = 0; d < 3; d++)
         checkOutput($sformatf("reset_outputs_%0d", d),
            {word_ready[d], config_nreset[d], config_enable[d], config_data[d], busy[d], done[d]}, 6'b0);
      reset = 1'b0;
      @(negedge clock);
      for (int d = 0; d < 3; d++)
         checkOutput($sformatf("idle_after_reset_%0d", d), {config_nreset[d], busy[d]}, 2'b10);

      for (int v = 0; v < 9; v++) begin
         $display("[TB] vector %0d", v);
         applyStimulus(v);
      end

      $display("[TB] reset during SHIFT");
      exp_q[0].delete();
      @(negedge clock);
      start[0] = 1'b1;
      word_valid[0] = 1'b1;
      word_data[0] = 32'hA5A5A5A5;
      @(negedge clock);
      start[0] = 1'b0;
      @(negedge clock);
      checkOutput("mid_ready", word_ready[0], 1);
      for (int k = 31; k >= 0; k--) exp_q[0].push_back(word_data[0][k]);
      repeat (8) @(negedge clock);
      checkOutput("mid_enable_before_reset", config_enable[0], 1);
      reset = 1'b1;
      @(negedge clock);
      checkOutput("mid_reset_outputs",
         {word_ready[0], config_nreset[0], config_enable[0], config_data[0], busy[0], done[0]}, 6'b0);
      exp_q[0].delete();
      reset = 1'b0;
      word_valid[0] = 1'b0;
      @(negedge clock);
      checkOutput("mid_idle_after_reset", {config_nreset[0], busy[0], config_enable[0]}, 3'b100);
      applyStimulus(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
